// File: rtl/steg_pkg.sv
// Shared types and constants for the extraction-path message deframer.
package steg_pkg;

  localparam int unsigned FF_DATA_WIDTH = 8;
  localparam int unsigned LEN_W         = 16;
  localparam logic [FF_DATA_WIDTH-1:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned MAX_LEN_DEFAULT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_LEN_LO  = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CHK     = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } dfr_state_e;

  // A frame is in progress from sync hunting up to the checksum byte.
  function automatic logic is_busy(input dfr_state_e st);
    return (st == ST_SYNC) || (st == ST_LEN_HI) || (st == ST_LEN_LO) ||
           (st == ST_PAYLOAD) || (st == ST_CHK);
  endfunction

endpackage

// File: rtl/ext_message_deframer_byte_hold_reg.sv
// One-entry valid/ready output register; flush drops the held entry.
module byte_hold_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         flush,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/ext_message_deframer.sv
// Drains the extract FIFO: sync hunt, 16-bit BE length, payload forwarding.
// Optional trailing XOR checksum when DEFRAME_CHECKSUM_EN is defined.
module ext_message_deframer
  import steg_pkg::*;
#(
  parameter logic [FF_DATA_WIDTH-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned              MAX_LEN   = MAX_LEN_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [FF_DATA_WIDTH-1:0] ff_data,
  input  logic                     ff_empty,
  output logic                     ff_rd,
  output logic [FF_DATA_WIDTH-1:0] msg_data,
  output logic                     msg_valid,
  input  logic                     msg_ready,
  output logic [LEN_W-1:0]         msg_len,
  output logic                     busy,
  output logic                     done,
  output logic                     len_err,
  output logic                     chk_err
);

  dfr_state_e       state_q, state_d;
  logic             ff_rd_q, ff_rd_d;
  logic             cap_q, cap_d;
  logic [LEN_W-1:0] msg_len_q, msg_len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             len_err_q, len_err_d;
`ifdef DEFRAME_CHECKSUM_EN
  logic [FF_DATA_WIDTH-1:0] chk_q, chk_d;
  logic                     chk_err_q, chk_err_d;
`endif

  logic             hold_load, hold_flush, hold_valid;
  logic             need_byte;
  logic [LEN_W-1:0] len_c;

  byte_hold_reg #(.W(FF_DATA_WIDTH)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (hold_load),
    .din   (ff_data),
    .flush (hold_flush),
    .ready (msg_ready),
    .valid (hold_valid),
    .dout  (msg_data)
  );

  always_comb begin
    state_d    = state_q;
    ff_rd_d    = 1'b0;
    cap_d      = ff_rd_q;
    msg_len_d  = msg_len_q;
    rem_d      = rem_q;
    done_d     = done_q;
    len_err_d  = len_err_q;
`ifdef DEFRAME_CHECKSUM_EN
    chk_d      = chk_q;
    chk_err_d  = chk_err_q;
`endif
    hold_load  = 1'b0;
    hold_flush = 1'b0;
    len_c      = {msg_len_q[LEN_W-1:FF_DATA_WIDTH], ff_data};

    unique case (state_q)
      ST_SYNC, ST_LEN_HI, ST_LEN_LO, ST_CHK: need_byte = 1'b1;
      ST_PAYLOAD: need_byte = !hold_valid && (rem_q != '0);
      default:    need_byte = 1'b0;
    endcase

    // One read in flight at a time: strobe, then capture, then the next strobe.
    if (need_byte && !ff_rd_q && !cap_q && !ff_empty) ff_rd_d = 1'b1;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d   = ST_SYNC;
          msg_len_d = '0;
          rem_d     = '0;
          done_d    = 1'b0;
          len_err_d = 1'b0;
`ifdef DEFRAME_CHECKSUM_EN
          chk_d     = '0;
          chk_err_d = 1'b0;
`endif
        end
      end
      ST_SYNC: begin
        if (cap_q && (ff_data == SYNC_BYTE)) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (cap_q) begin
          msg_len_d = {ff_data, FF_DATA_WIDTH'(0)};
`ifdef DEFRAME_CHECKSUM_EN
          chk_d     = ff_data;
`endif
          state_d   = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (cap_q) begin
          msg_len_d = len_c;
          rem_d     = len_c;
`ifdef DEFRAME_CHECKSUM_EN
          chk_d     = chk_q ^ ff_data;
`endif
          if (32'(len_c) > MAX_LEN) begin
            state_d   = ST_ERROR;
            len_err_d = 1'b1;
          end else if (len_c == '0) begin
`ifdef DEFRAME_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (cap_q) begin
          hold_load = 1'b1;
          if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
`ifdef DEFRAME_CHECKSUM_EN
          chk_d     = chk_q ^ ff_data;
`endif
        end
        // Frame body ends only once the consumer has taken the final byte.
        if (hold_valid && msg_ready && (rem_q == '0)) begin
`ifdef DEFRAME_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef DEFRAME_CHECKSUM_EN
      ST_CHK: begin
        if (cap_q) begin
          if (ff_data == chk_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_ERROR;
            chk_err_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      state_d    = ST_IDLE;
      ff_rd_d    = 1'b0;
      cap_d      = 1'b0;
      hold_load  = 1'b0;
      hold_flush = 1'b1;
      rem_d      = '0;
      done_d     = 1'b0;
      len_err_d  = 1'b0;
`ifdef DEFRAME_CHECKSUM_EN
      chk_d      = '0;
      chk_err_d  = 1'b0;
`endif
    end

    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ff_rd_q   <= 1'b0;
      cap_q     <= 1'b0;
      msg_len_q <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
`ifdef DEFRAME_CHECKSUM_EN
      chk_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ff_rd_q   <= ff_rd_d;
      cap_q     <= cap_d;
      msg_len_q <= msg_len_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
`ifdef DEFRAME_CHECKSUM_EN
      chk_q     <= chk_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

  assign ff_rd     = ff_rd_q;
  assign msg_valid = hold_valid;
  assign msg_len   = msg_len_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign len_err   = len_err_q;
`ifdef DEFRAME_CHECKSUM_EN
  assign chk_err   = chk_err_q;
`else
  assign chk_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ext_message_deframer.sv
// Scoreboard bench for ext_message_deframer: FIFO model feeds frames, payload checked on accept.
module tb_ext_message_deframer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [7:0]  ff_data;
  logic        ff_empty;
  logic        ff_rd;
  logic [7:0]  msg_data;
  logic        msg_valid;
  logic        msg_ready;
  logic [15:0] msg_len;
  logic        busy, done, len_err, chk_err;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [7:0]  fifo_q [$];
  logic [7:0]  exp_q  [$];
  int          rx_count = 0;
  int          rd_viol  = 0;
  logic        empty_gate = 1'b0;
  logic        gate_rand  = 1'b0;

  always #5 clk = ~clk;

  ext_message_deframer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .ff_data   (ff_data),
    .ff_empty  (ff_empty),
    .ff_rd     (ff_rd),
    .msg_data  (msg_data),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_len   (msg_len),
    .busy      (busy),
    .done      (done),
    .len_err   (len_err),
    .chk_err   (chk_err)
  );

  assign ff_empty = (fifo_q.size() == 0) || empty_gate;

  // FIFO model: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (ff_rd && fifo_q.size() > 0) ff_data <= fifo_q.pop_front();
  end

  always @(posedge clk) begin
    #1;
    empty_gate = gate_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on accept, hold stability, read-strobe protocol.
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0, prev_rd = 1'b0;
  logic       prev_empty = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ff_rd && prev_rd) rd_viol++;
      if (ff_rd && prev_empty) rd_viol++;
      if (ff_rd && msg_valid) rd_viol++;
      if (prev_valid && !prev_ready && !prev_abort) begin
        check_eq("hold_valid", 32'(msg_valid), 32'd1);
        check_eq("hold_data", 32'(msg_data), 32'(prev_data));
      end
      if (msg_valid && msg_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_byte", 32'(msg_data), 32'hFFFF_FFFF);
        else check_eq("payload", 32'(msg_data), 32'(exp_q.pop_front()));
        rx_count++;
      end
    end
    prev_valid = msg_valid && rst_n;
    prev_ready = msg_ready;
    prev_abort = abort;
    prev_data  = msg_data;
    prev_rd    = ff_rd;
    prev_empty = ff_empty;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Pushes a frame into the FIFO model and its payload into the scoreboard.
  task automatic send_frame(input logic [7:0] pl [$], input bit bad_chk);
    logic [15:0] len;
    logic [7:0]  chk;
    len = 16'(pl.size());
    chk = len[15:8] ^ len[7:0];
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(len[15:8]);
    fifo_q.push_back(len[7:0]);
    foreach (pl[i]) begin
      fifo_q.push_back(pl[i]);
      exp_q.push_back(pl[i]);
      chk = chk ^ pl[i];
    end
`ifdef DEFRAME_CHECKSUM_EN
    fifo_q.push_back(bad_chk ? ~chk : chk);
`else
    if (bad_chk) fifo_q.push_back(8'h00);
`endif
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(done || len_err || chk_err) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check_eq({tag, "_timeout"}, 32'(n), 32'(budget - 1));
  endtask

  task automatic wait_rx(input string tag, input int target, input int budget);
    int n = 0;
    while (rx_count < target && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check_eq({tag, "_timeout"}, 32'(rx_count), 32'(target));
  endtask

  task automatic flush_model();
    fifo_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] pl [$];
    int base;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; msg_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst_outputs", {ff_rd, msg_valid, busy, done, len_err, chk_err}, 32'd0);
    check_eq("rst_msg_len", 32'(msg_len), 32'd0);
    check_eq("rst_msg_data", 32'(msg_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic 3-byte frame.
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(pl, 1'b0);
    pulse_start();
    check_eq("busy_after_start", 32'(busy), 32'd1);
    wait_end("frame1", 200);
    check_eq("f1_done", 32'(done), 32'd1);
    check_eq("f1_errs", {len_err, chk_err}, 32'd0);
    check_eq("f1_len", 32'(msg_len), 32'd3);
    check_eq("f1_drained", 32'(exp_q.size()), 32'd0);
    check_eq("f1_busy", 32'(busy), 32'd0);

    // Junk before sync, single-byte payload.
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    pl = '{8'h7E};
    send_frame(pl, 1'b0);
    pulse_start();
    check_eq("f2_done_cleared", 32'(done), 32'd0);
    wait_end("frame2", 200);
    check_eq("f2_done", 32'(done), 32'd1);
    check_eq("f2_len", 32'(msg_len), 32'd1);
    check_eq("f2_drained", 32'(exp_q.size()), 32'd0);

    // Oversized length: no further reads after the length bytes.
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h20); fifo_q.push_back(8'h00);
    fifo_q.push_back(8'h55); fifo_q.push_back(8'h66);
    pulse_start();
    wait_end("frame3", 200);
    repeat (20) tick();
    check_eq("f3_len_err", 32'(len_err), 32'd1);
    check_eq("f3_done", 32'(done), 32'd0);
    check_eq("f3_len", 32'(msg_len), 32'h2000);
    check_eq("f3_fifo_left", 32'(fifo_q.size()), 32'd2);
    flush_model();

    // Maximum legal length 4096 is accepted.
    pl.delete();
    for (int i = 0; i < 4096; i++) pl.push_back(8'($urandom));
    send_frame(pl, 1'b0);
    pulse_start();
    check_eq("f4_len_err_cleared", 32'(len_err), 32'd0);
    wait_end("frame_max", 20000);
    check_eq("fmax_done", 32'(done), 32'd1);
    check_eq("fmax_len", 32'(msg_len), 32'd4096);
    check_eq("fmax_drained", 32'(exp_q.size()), 32'd0);

`ifdef DEFRAME_CHECKSUM_EN
    // Corrupted checksum: payload still delivered, chk_err raised.
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(pl, 1'b1);
    pulse_start();
    wait_end("frame_badchk", 200);
    check_eq("bc_chk_err", 32'(chk_err), 32'd1);
    check_eq("bc_done", 32'(done), 32'd0);
    check_eq("bc_drained", 32'(exp_q.size()), 32'd0);
`endif

    // Backpressure with a flaky empty flag; a start mid-frame is ignored.
    pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    send_frame(pl, 1'b0);
    gate_rand = 1'b1;
    pulse_start();
    base = rx_count;
    wait_rx("bp_first", base + 2, 400);
    msg_ready = 1'b0;
    pulse_start();
    repeat (9) tick();
    check_eq("bp_held_count", 32'(rx_count), 32'(base + 2));
    check_eq("bp_busy", 32'(busy), 32'd1);
    msg_ready = 1'b1;
    wait_end("bp_frame", 600);
    gate_rand = 1'b0;
    check_eq("bp_done", 32'(done), 32'd1);
    check_eq("bp_count", 32'(rx_count), 32'(base + 6));
    check_eq("bp_drained", 32'(exp_q.size()), 32'd0);

    // Abort after the second payload byte, then a fresh frame.
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(pl, 1'b0);
    pulse_start();
    base = rx_count;
    wait_rx("ab_first", base + 2, 400);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_idle", {msg_valid, busy, ff_rd, done}, 32'd0);
    flush_model();
    repeat (5) tick();
    check_eq("ab_quiet", {msg_valid, busy, ff_rd}, 32'd0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_eq("ab_wins", 32'(busy), 32'd0);
    pl = '{8'h9A, 8'hBC};
    send_frame(pl, 1'b0);
    pulse_start();
    wait_end("ab_frame", 300);
    check_eq("ab_new_done", 32'(done), 32'd1);
    check_eq("ab_new_len", 32'(msg_len), 32'd2);
    check_eq("ab_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame, then a fresh frame.
    pl = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    send_frame(pl, 1'b0);
    pulse_start();
    base = rx_count;
    wait_rx("rs_first", base + 2, 400);
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("rs_outputs", {ff_rd, msg_valid, busy, done, len_err, chk_err}, 32'd0);
    check_eq("rs_len", 32'(msg_len), 32'd0);
    flush_model();
    rst_n = 1'b1;
    tick();
    pl = '{8'hE7, 8'h00, 8'hFF};
    send_frame(pl, 1'b0);
    pulse_start();
    wait_end("rs_frame", 300);
    check_eq("rs_new_done", 32'(done), 32'd1);
    check_eq("rs_new_len", 32'(msg_len), 32'd3);
    check_eq("rs_drained", 32'(exp_q.size()), 32'd0);

    check_eq("rd_protocol", 32'(rd_viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
